// File: rtl/sc_fifo_ext.sv
// sc_fifo_ext: single-clock FIFO with show-ahead or normal read mode, programmable
// almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow flags.

module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register resets to zero and holds its value between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

module sc_fifo_ext #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 8,
  parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
  parameter bit SHOW_AHEAD   = 1'b1,
  parameter int AFULL_LVL    = WORDS_AMOUNT - 2,
  parameter int AEMPTY_LVL   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   used_words_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam logic [ADDR_WIDTH:0] CAPACITY  = (ADDR_WIDTH + 1)'(WORDS_AMOUNT);
  localparam logic [ADDR_WIDTH:0] AFULL_W   = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_W  = (ADDR_WIDTH + 1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   used_words;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_q;

  assign wr_acc  = wr_i && !full_o && !flush_i;
  assign rd_acc  = rd_i && !empty_o && !flush_i;
  assign ovf_set = wr_i && full_o && !flush_i;
  assign unf_set = rd_i && empty_o && !flush_i;

  assign used_words_o   = used_words;
  assign full_o         = (used_words == CAPACITY);
  assign almost_full_o  = (used_words >= AFULL_W);
  assign almost_empty_o = (used_words <= AEMPTY_W);

  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data_i),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // Write pointer, RAM fetch pointer and total word count; flush clears them like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used_words <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   used_words <= used_words + CNT_ONE;
        2'b01:   used_words <= used_words - CNT_ONE;
        default: used_words <= used_words;
      endcase
    end
  end

  // Sticky error flags survive flush; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (unf_set) begin
        underflow_o <= 1'b1;
      end else if (clr_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      // Two-stage prefetch: the RAM read register feeds the head-word output register.
      logic                  s1_valid;
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;
      logic [ADDR_WIDTH:0]   ram_words;
      logic                  s1_move;

      assign ram_words = used_words - (ADDR_WIDTH + 1)'(s1_valid)
                                    - (ADDR_WIDTH + 1)'(out_valid);
      assign s1_move   = s1_valid && (!out_valid || rd_acc);
      assign ram_rd_en = !flush_i && (ram_words != '0) && (!s1_valid || s1_move);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s1_valid  <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (flush_i) begin
          s1_valid  <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          if (ram_rd_en) begin
            s1_valid <= 1'b1;
          end else if (s1_move) begin
            s1_valid <= 1'b0;
          end
          if (s1_move) begin
            out_valid <= 1'b1;
            out_data  <= ram_q;
          end else if (rd_acc) begin
            out_valid <= 1'b0;
          end
        end
      end

      assign empty_o    = !out_valid;
      assign rd_valid_o = out_valid;
      assign rd_data_o  = out_data;
    end else begin : g_normal
      logic rd_valid_q;

      assign ram_rd_en = rd_acc;

      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
        end
      end

      assign empty_o    = (used_words == '0);
      assign rd_valid_o = rd_valid_q;
      assign rd_data_o  = ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_sc_fifo_ext.sv
// Directed bench for sc_fifo_ext: one show-ahead instance and one normal-mode instance,
// each driven separately, with hand-computed expectations.

module tb_sc_fifo_ext;

  logic       clk = 1'b0;
  logic       rst;

  logic       sa_flush, sa_wr, sa_rd, sa_clr;
  logic [7:0] sa_wr_data;
  logic [7:0] sa_rd_data;
  logic [3:0] sa_used;
  logic       sa_rd_valid, sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;

  logic       nm_flush, nm_wr, nm_rd, nm_clr;
  logic [7:0] nm_wr_data;
  logic [7:0] nm_rd_data;
  logic [3:0] nm_used;
  logic       nm_rd_valid, nm_full, nm_empty, nm_af, nm_ae, nm_ovf, nm_unf;

  logic [6:0] sa_flags;
  logic [6:0] nm_flags;

  int checks = 0;
  int errors = 0;

  // {rd_valid, full, empty, almost_full, almost_empty, overflow, underflow}
  localparam logic [6:0] RESET_FLAGS = 7'b0010100;

  assign sa_flags = {sa_rd_valid, sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf};
  assign nm_flags = {nm_rd_valid, nm_full, nm_empty, nm_af, nm_ae, nm_ovf, nm_unf};

  always #5 clk = ~clk;

  sc_fifo_ext #(
    .DATA_WIDTH   (8),
    .WORDS_AMOUNT (8),
    .SHOW_AHEAD   (1'b1)
  ) dut_sa (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (sa_flush),
    .wr_i           (sa_wr),
    .wr_data_i      (sa_wr_data),
    .rd_i           (sa_rd),
    .rd_data_o      (sa_rd_data),
    .rd_valid_o     (sa_rd_valid),
    .used_words_o   (sa_used),
    .full_o         (sa_full),
    .empty_o        (sa_empty),
    .almost_full_o  (sa_af),
    .almost_empty_o (sa_ae),
    .overflow_o     (sa_ovf),
    .underflow_o    (sa_unf),
    .clr_err_i      (sa_clr)
  );

  sc_fifo_ext #(
    .DATA_WIDTH   (8),
    .WORDS_AMOUNT (8),
    .SHOW_AHEAD   (1'b0)
  ) dut_nm (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (nm_flush),
    .wr_i           (nm_wr),
    .wr_data_i      (nm_wr_data),
    .rd_i           (nm_rd),
    .rd_data_o      (nm_rd_data),
    .rd_valid_o     (nm_rd_valid),
    .used_words_o   (nm_used),
    .full_o         (nm_full),
    .empty_o        (nm_empty),
    .almost_full_o  (nm_af),
    .almost_empty_o (nm_ae),
    .overflow_o     (nm_ovf),
    .underflow_o    (nm_unf),
    .clr_err_i      (nm_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle on the selected instance, then returns 1 ns after the edge with inputs idle.
  task automatic applyStimulus(input bit sel_nm, input logic wr, input logic [7:0] data,
                               input logic rd, input logic flush, input logic clr);
    if (sel_nm) begin
      nm_wr = wr; nm_wr_data = data; nm_rd = rd; nm_flush = flush; nm_clr = clr;
    end else begin
      sa_wr = wr; sa_wr_data = data; sa_rd = rd; sa_flush = flush; sa_clr = clr;
    end
    @(posedge clk);
    #1;
    sa_wr = 1'b0; sa_wr_data = '0; sa_rd = 1'b0; sa_flush = 1'b0; sa_clr = 1'b0;
    nm_wr = 1'b0; nm_wr_data = '0; nm_rd = 1'b0; nm_flush = 1'b0; nm_clr = 1'b0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sa_wr = 1'b0; sa_wr_data = '0; sa_rd = 1'b0; sa_flush = 1'b0; sa_clr = 1'b0;
    nm_wr = 1'b0; nm_wr_data = '0; nm_rd = 1'b0; nm_flush = 1'b0; nm_clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sa_reset_flags", sa_flags, RESET_FLAGS);
    checkOutput("sa_reset_used", sa_used, 0);
    checkOutput("sa_reset_data", sa_rd_data, 0);
    checkOutput("nm_reset_flags", nm_flags, RESET_FLAGS);
    checkOutput("nm_reset_used", nm_used, 0);
    checkOutput("nm_reset_data", nm_rd_data, 0);
    rst = 1'b0;

    // Normal mode: data one cycle after the read, valid pulses once
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("nm_wr_used", nm_used, 1);
    checkOutput("nm_wr_empty", nm_empty, 0);
    checkOutput("nm_wr_valid", nm_rd_valid, 0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("nm_rd_data", nm_rd_data, 8'hA5);
    checkOutput("nm_rd_valid", nm_rd_valid, 1);
    checkOutput("nm_rd_used", nm_used, 0);
    checkOutput("nm_rd_empty", nm_empty, 1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("nm_valid_pulse", nm_rd_valid, 0);
    checkOutput("nm_data_hold", nm_rd_data, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("nm_underflow", nm_unf, 1);
    checkOutput("nm_unf_valid", nm_rd_valid, 0);
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    checkOutput("nm_wrrd_data", nm_rd_data, 8'h11);
    checkOutput("nm_wrrd_used", nm_used, 1);
    checkOutput("nm_clr_unf", nm_unf, 0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("nm_second_data", nm_rd_data, 8'h22);
    checkOutput("nm_second_used", nm_used, 0);

    // Show-ahead fill: head word appears two edges after the first write
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      checkOutput("t1_used", sa_used, k);
      if (k <= 2) checkOutput("t1_empty_early", sa_empty, 1);
      if (k == 2) checkOutput("t1_aempty_at2", sa_ae, 1);
      if (k == 3) begin
        checkOutput("t1_empty_late", sa_empty, 0);
        checkOutput("t1_head", sa_rd_data, 8'h01);
        checkOutput("t1_aempty_at3", sa_ae, 0);
      end
      if (k == 5) checkOutput("t1_afull_at5", sa_af, 0);
      if (k == 6) checkOutput("t1_afull_at6", sa_af, 1);
      if (k == 7) checkOutput("t1_full_at7", sa_full, 0);
      if (k == 8) checkOutput("t1_full_at8", sa_full, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      checkOutput("t1_rd_data", sa_rd_data, k);
      checkOutput("t1_rd_valid", sa_rd_valid, 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("t1_drained_empty", sa_empty, 1);
    checkOutput("t1_drained_used", sa_used, 0);
    checkOutput("t1_no_unf", sa_unf, 0);

    // Full FIFO: simultaneous write is dropped, read is taken
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t3_full", sa_full, 1);
    checkOutput("t3_head", sa_rd_data, 8'h10);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_used", sa_used, 7);
    checkOutput("t3_ovf", sa_ovf, 1);
    checkOutput("t3_not_full", sa_full, 0);
    checkOutput("t3_next_head", sa_rd_data, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_refull", sa_full, 1);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_err_wins_clr", sa_ovf, 1);
    checkOutput("t3_used_full", sa_used, 8);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_ovf_cleared", sa_ovf, 0);
    for (int k = 1; k <= 8; k++) begin
      checkOutput("t3_rd_data", sa_rd_data, 8'(8'h10 + k));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("t3_drained", sa_empty, 1);

    // Underflow and write+read on empty
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_unf", sa_unf, 1);
    checkOutput("t4_used0", sa_used, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_unf_cleared", sa_unf, 0);
    applyStimulus(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_wrrd_used", sa_used, 1);
    checkOutput("t4_wrrd_unf", sa_unf, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_still_empty", sa_empty, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_visible", sa_empty, 0);
    checkOutput("t4_head", sa_rd_data, 8'hC3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_read_clr_unf", sa_unf, 0);
    checkOutput("t4_used_after", sa_used, 0);

    // Wrap: steady write+read keeps three words in flight across pointer wrap
    for (int k = 0; k < 23; k++) begin
      if (k >= 3) checkOutput("t5_rd_data", sa_rd_data, 8'(8'h30 + k - 3));
      if (k == 10) checkOutput("t5_used", sa_used, 3);
      applyStimulus(1'b0, k < 20, 8'(8'h30 + k), k >= 3, 1'b0, 1'b0);
    end
    checkOutput("t5_empty", sa_empty, 1);
    checkOutput("t5_used_end", sa_used, 0);
    checkOutput("t5_no_errors", {sa_ovf, sa_unf}, 2'b00);

    // Flush with write and read requests pending
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_used5", sa_used, 5);
    checkOutput("t6_head", sa_rd_data, 8'h50);
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_flush_flags", sa_flags, RESET_FLAGS);
    checkOutput("t6_flush_used", sa_used, 0);
    checkOutput("t6_flush_data_kept", sa_rd_data, 8'h50);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_flush_write_ignored", sa_empty, 1);

    // Reset in the middle of a burst with a sticky flag set
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_pre_unf", sa_unf, 1);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t6_pre_head", sa_rd_data, 8'h61);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h64, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t6_rst_flags", sa_flags, RESET_FLAGS);
    checkOutput("t6_rst_used", sa_used, 0);
    checkOutput("t6_rst_data", sa_rd_data, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_rst_data_gone", sa_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
